// File: rtl/nco_pkg.sv
// nco_pkg: widths, CORDIC arctangent table and shared helpers for the NCO and phase/frequency detector
package nco_pkg;
   localparam int DATA_W     = 8;
   localparam int INT_W      = 10;
   localparam int ITER_COUNT = 7;
   localparam int IDX_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {IDLE, ITER, DONE} pfd_state_t;

   // atan(2^-i) with one full turn = 256 LSB
   function automatic logic [DATA_W-1:0] atan_lut(input logic [IDX_W-1:0] i);
      case (i)
         3'd0:    return 8'd32;
         3'd1:    return 8'd19;
         3'd2:    return 8'd10;
         3'd3:    return 8'd5;
         3'd4:    return 8'd3;
         default: return 8'd1;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] circ_dist(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] d;
      d = a - b;
      return d[DATA_W-1] ? -d : d;
   endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one CORDIC vectoring micro-rotation driving y toward zero
module cordic_vec_stage
   import nco_pkg::*;
(
   input  logic signed [INT_W-1:0]  x,
   input  logic signed [INT_W-1:0]  y,
   input  logic        [DATA_W-1:0] z,
   input  logic        [IDX_W-1:0]  i,
   output logic signed [INT_W-1:0]  x_next,
   output logic signed [INT_W-1:0]  y_next,
   output logic        [DATA_W-1:0] z_next
);
   logic signed [INT_W-1:0] xs, ys;
   logic pos;
   assign pos    = !y[INT_W-1];
   assign xs     = x >>> i;
   assign ys     = y >>> i;
   assign x_next = pos ? x + ys : x - ys;
   assign y_next = pos ? y - xs : y + xs;
   assign z_next = pos ? z + atan_lut(i) : z - atan_lut(i);
endmodule

// File: rtl/phase_freq_detector.sv
// phase_freq_detector: CORDIC angle of (I,Q), phase-step frequency estimate and lock detection
module phase_freq_detector
   import nco_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOCK_TOL   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] sin_in,
   input  logic [DATA_W-1:0] cos_in,
   output logic              out_valid,
   output logic [DATA_W-1:0] phase_out,
   output logic [DATA_W-1:0] freq_out,
   output logic              locked
);
   localparam int CNT_W = $clog2(LOCK_COUNT + 1);

   pfd_state_t state, state_next;
   logic signed [INT_W-1:0] x, y, x_next, y_next, i_ext, q_ext;
   logic [DATA_W-1:0] z, z_next, phase, freq;
   logic [IDX_W-1:0] idx;
   logic [1:0] res_cnt;
   logic [CNT_W-1:0] lock_cnt, lock_next;
   logic zero_in, accept, neg, consistent;

   cordic_vec_stage stage (
      .x(x), .y(y), .z(z), .i(idx),
      .x_next(x_next), .y_next(y_next), .z_next(z_next)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = in_valid ? ITER : IDLE;
         ITER:    state_next = idx == IDX_W'(ITER_COUNT - 1) ? DONE : ITER;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready = state == IDLE;
   assign accept   = in_valid && in_ready;
   assign neg      = cos_in[DATA_W-1];
   assign i_ext    = {{(INT_W-DATA_W){cos_in[DATA_W-1]}}, cos_in};
   assign q_ext    = {{(INT_W-DATA_W){sin_in[DATA_W-1]}}, sin_in};

   // phase_out/freq_out double as the stored previous phase and frequency
   assign phase      = zero_in ? '0 : z;
   assign freq       = res_cnt == 2'd0 ? '0 : phase - phase_out;
   assign consistent = res_cnt == 2'd2 && circ_dist(freq, freq_out) <= DATA_W'(LOCK_TOL);
   assign lock_next  = !consistent ? '0 :
                       lock_cnt == CNT_W'(LOCK_COUNT) ? lock_cnt : lock_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         phase_out <= '0;
         freq_out  <= '0;
         locked    <= 1'b0;
         lock_cnt  <= '0;
         res_cnt   <= '0;
      end else begin
         state     <= state_next;
         out_valid <= state == DONE;
         if (state == DONE) begin
            phase_out <= phase;
            freq_out  <= freq;
            lock_cnt  <= lock_next;
            locked    <= lock_next == CNT_W'(LOCK_COUNT);
            res_cnt   <= res_cnt == 2'd2 ? res_cnt : res_cnt + 2'd1;
         end
      end
   end

   // pre-rotation into the right half-plane, then one micro-rotation per ITER cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         x       <= neg ? -i_ext : i_ext;
         y       <= neg ? -q_ext : q_ext;
         z       <= neg ? DATA_W'(1 << (DATA_W - 1)) : '0;
         idx     <= '0;
         zero_in <= cos_in == '0 && sin_in == '0;
      end else if (state == ITER) begin
         x   <= x_next;
         y   <= y_next;
         z   <= z_next;
         idx <= idx + IDX_W'(1);
      end
   end
endmodule

// File: tb/tb_phase_freq_detector.sv
// tb_phase_freq_detector: directed vectors plus reset-abort, back-pressure and NCO lock sequences
module tb_phase_freq_detector;
   logic clk = 1'b0;
   logic reset, in_valid, in_ready, out_valid, locked;
   logic [7:0] sin_in, cos_in, phase_out, freq_out;

   always #5 clk = ~clk;

   phase_freq_detector #(.LOCK_COUNT(4), .LOCK_TOL(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sin_in(sin_in), .cos_in(cos_in), .out_valid(out_valid),
      .phase_out(phase_out), .freq_out(freq_out), .locked(locked)
   );

   typedef struct {
      bit         rst;
      logic [7:0] c;
      logic [7:0] s;
      int         ph;
      int         fr;
      bit         lk;
      int         ideal;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   int atan_t [7] = '{32, 19, 10, 5, 3, 1, 1};

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_near(input string name, input int act, input int exp, input int tol);
      int d;
      d = (act - exp) & 255;
      d = d > 127 ? 256 - d : d;
      n_chk++;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   // independent model of the vectoring algorithm on plain integers
   function automatic int ref_phase(input int c, input int s);
      int x, y, z, t;
      if (c == 0 && s == 0) return 0;
      x = c < 0 ? -c : c;
      y = c < 0 ? -s : s;
      z = c < 0 ? 128 : 0;
      for (int i = 0; i < 7; i++) begin
         t = x;
         if (y >= 0) begin
            x = x + (y >>> i); y = y - (t >>> i); z = z + atan_t[i];
         end else begin
            x = x - (y >>> i); y = y + (t >>> i); z = z - atan_t[i];
         end
      end
      return z & 255;
   endfunction

   function automatic int cdist(input int a, input int b);
      int d;
      d = (a - b) & 255;
      return d > 127 ? 256 - d : d;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // returns at the negedge where out_valid is seen; lat = edges after the acceptance edge
   task automatic do_sample(input logic [7:0] c, input logic [7:0] s, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_sample", int'(in_ready), 1);
      cos_in = c;
      sin_in = s;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv [25];
      int lat, rdy_cnt, acc_cnt, ov_cnt, p, inc, ci, si, ph, fr, m_n, m_ph, m_fr, m_cnt;

      tv[0]  = '{0, 8'd127, 8'd0,   1,   0,   0, 0};
      tv[1]  = '{0, 8'd0,   8'd127, 63,  62,  0, 64};
      tv[2]  = '{0, 8'h80,  8'd0,   129, 66,  0, 128};
      tv[3]  = '{0, 8'd0,   8'h80,  193, 64,  0, 192};
      tv[4]  = '{0, 8'd117, 8'd49,  15,  78,  0, 16};
      tv[5]  = '{0, 8'd90,  8'd90,  31,  16,  0, 32};
      tv[6]  = '{0, 8'd49,  8'd117, 49,  18,  0, 48};
      tv[7]  = '{0, 8'd0,   8'd0,   0,   207, 0, 0};
      // lock sequence: saturation, circular +/-1 tolerance, drop and relock
      tv[8]  = '{1, 8'd127, 8'd0,   1,   0,   0, -1};
      tv[9]  = '{0, 8'd127, 8'd0,   1,   0,   0, -1};
      tv[10] = '{0, 8'd127, 8'd0,   1,   0,   0, -1};
      tv[11] = '{0, 8'd127, 8'd0,   1,   0,   0, -1};
      tv[12] = '{0, 8'd127, 8'd0,   1,   0,   0, -1};
      tv[13] = '{0, 8'd127, 8'd0,   1,   0,   1, -1};
      tv[14] = '{0, 8'd127, 8'd0,   1,   0,   1, -1};
      tv[15] = '{0, 8'd0,   8'd0,   0,   255, 1, -1};
      tv[16] = '{0, 8'd0,   8'd0,   0,   0,   1, -1};
      tv[17] = '{0, 8'd127, 8'd0,   1,   1,   1, -1};
      tv[18] = '{0, 8'd0,   8'd0,   0,   255, 0, -1};
      tv[19] = '{0, 8'd0,   8'd127, 63,  63,  0, -1};
      tv[20] = '{0, 8'd0,   8'd127, 63,  0,   0, -1};
      tv[21] = '{0, 8'd0,   8'd127, 63,  0,   0, -1};
      tv[22] = '{0, 8'd0,   8'd127, 63,  0,   0, -1};
      tv[23] = '{0, 8'd0,   8'd127, 63,  0,   0, -1};
      tv[24] = '{0, 8'd0,   8'd127, 63,  0,   1, -1};

      reset = 1'b1;
      in_valid = 1'b0;
      cos_in = '0;
      sin_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_phase", int'(phase_out), 0);
      chk("reset_freq", int'(freq_out), 0);
      chk("reset_locked", int'(locked), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 25; k++) begin
         if (tv[k].rst) do_reset();
         do_sample(tv[k].c, tv[k].s, lat);
         chk($sformatf("latency[%0d]", k), lat, 8);
         chk($sformatf("phase[%0d]", k), int'(phase_out), tv[k].ph);
         chk($sformatf("freq[%0d]", k), int'(freq_out), tv[k].fr);
         chk($sformatf("locked[%0d]", k), int'(locked), int'(tv[k].lk));
         if (tv[k].ideal >= 0) chk_near($sformatf("phase_ideal[%0d]", k), int'(phase_out), tv[k].ideal, 2);
         @(negedge clk);
         chk($sformatf("strobe_low[%0d]", k), int'(out_valid), 0);
         chk($sformatf("phase_hold[%0d]", k), int'(phase_out), tv[k].ph);
      end

      // reset in the third ITER cycle aborts the sample
      chk("abort_pre_locked", int'(locked), 1);
      cos_in = 8'd90;
      sin_in = 8'd90;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_in_ready_0", int'(in_ready), 1);
      @(negedge clk);
      chk("abort_in_ready_1", int'(in_ready), 1);
      ov_cnt = 0;
      for (int j = 0; j < 15; j++) begin
         ov_cnt += int'(out_valid);
         @(negedge clk);
      end
      chk("abort_no_strobe", ov_cnt, 0);
      chk("abort_phase", int'(phase_out), 0);
      chk("abort_freq", int'(freq_out), 0);
      chk("abort_locked", int'(locked), 0);
      do_sample(8'd127, 8'd0, lat);
      chk("post_abort_latency", lat, 8);
      chk("post_abort_phase", int'(phase_out), 1);
      chk("post_abort_freq", int'(freq_out), 0);
      @(negedge clk);

      // in_valid held high: one acceptance per 9 cycles
      cos_in = 8'd127;
      sin_in = 8'd0;
      in_valid = 1'b1;
      rdy_cnt = 0;
      acc_cnt = 0;
      ov_cnt = 0;
      for (int j = 0; j < 27; j++) begin
         rdy_cnt += int'(in_ready);
         acc_cnt += int'(in_ready && in_valid);
         ov_cnt += int'(out_valid);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stream_ready_cycles", rdy_cnt, 3);
      chk("stream_acceptances", acc_cnt, 3);
      chk("stream_strobes", ov_cnt, 2);
      chk("stream_third_strobe", int'(out_valid), 1);

      // NCO tone at 0x10 then 0x30, checked against the integer model
      do_reset();
      p = 0;
      m_n = 0;
      m_ph = 0;
      m_fr = 0;
      m_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         inc = k < 10 ? 16 : 48;
         ci = int'(127.0 * $cos(6.283185307179586 * p / 256.0));
         si = int'(127.0 * $sin(6.283185307179586 * p / 256.0));
         do_sample(8'(ci), 8'(si), lat);
         ph = ref_phase(ci, si);
         fr = m_n == 0 ? 0 : (ph - m_ph) & 255;
         m_cnt = (m_n >= 2 && cdist(fr, m_fr) <= 1) ? (m_cnt < 4 ? m_cnt + 1 : 4) : 0;
         m_n++;
         m_ph = ph;
         m_fr = fr;
         chk($sformatf("nco_latency[%0d]", k), lat, 8);
         chk($sformatf("nco_phase[%0d]", k), int'(phase_out), ph);
         chk($sformatf("nco_freq[%0d]", k), int'(freq_out), fr);
         chk($sformatf("nco_locked[%0d]", k), int'(locked), int'(m_cnt == 4));
         p = (p + inc) & 255;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/phase_freq_detector.md
PHASE_FREQ_DETECTOR -- requirements
Module: phase_freq_detector

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive consistent frequency results required to assert locked.
REQ-002 SHALL have parameter LOCK_TOL, default 1: maximum |freq_out - previous freq_out| counted as consistent, in LSB.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, sample present on sin_in/cos_in.
REQ-006 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-007 SHALL have port sin_in, input, 8, quadrature sample Q, two's complement.
REQ-008 SHALL have port cos_in, input, 8, in-phase sample I, two's complement.
REQ-009 SHALL have port out_valid, output, 1, one-cycle strobe qualifying phase_out/freq_out.
REQ-010 SHALL have port phase_out, output, 8, angle of (I,Q); 256 LSB = one full turn.
REQ-011 SHALL have port freq_out, output, 8, phase step between consecutive results, modulo 256; recovered phase increment.
REQ-012 SHALL have port locked, output, 1, frequency estimate stable.

Function
REQ-013 SHALL use a three-state FSM: IDLE, ITER, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; a sample is accepted on an edge where in_valid and in_ready are both high.
REQ-015 SHALL, on acceptance, pre-rotate into the right half-plane: if I<0, then x=-I, y=-Q, z=128; else x=I, y=Q, z=0.
REQ-016 SHALL hold x/y in 10-bit signed registers so that negating -128 does not overflow.
REQ-017 SHALL run CORDIC vectoring in ITER for exactly 7 cycles, i=0..6, one iteration per cycle: if y>=0, then x+=y>>>i, y-=x>>>i, z+=ATAN[i]; else the opposite signs; shifts are arithmetic.
REQ-018 SHALL use ATAN[0..6] = 32, 19, 10, 5, 3, 1, 1.
REQ-019 SHALL enter DONE after the 7th iteration, assert out_valid for that one cycle, and then return to IDLE.
REQ-020 SHALL give latency as follows: acceptance at edge k gives out_valid high in the cycle following edge k+8; throughput is one sample per 9 cycles.
REQ-021 SHALL make phase_out = z modulo 256, accurate to within ±2 LSB for |I|,|Q| magnitude ≥ 32.
REQ-022 SHALL make phase_out = 0 for input (0,0).
REQ-023 SHALL make freq_out = phase_out - previous phase_out modulo 256; on the first result after reset, freq_out = 0.
REQ-024 SHALL increment the lock counter, saturating at LOCK_COUNT, on each result after the second whose freq differs from the previous freq by ≤ LOCK_TOL, using modulo-256 circular distance.
REQ-025 SHALL clear the lock counter on any other result.
REQ-026 SHALL assert locked when the counter equals LOCK_COUNT; it updates in the same cycle as out_valid.
REQ-027 SHALL hold phase_out, freq_out and locked between out_valid strobes.
REQ-028 SHALL ignore in_valid outside IDLE and SHALL NOT drop or queue samples; the upstream holds the sample until in_ready.

Reset
REQ-029 SHALL, on reset, force the state to IDLE; in_ready goes to 1 on the next cycle.
REQ-030 SHALL, on reset, clear out_valid, phase_out, freq_out, locked, the lock counter, the stored previous phase/freq and the first-result flag.
REQ-031 SHALL abort any ITER/DONE operation when reset is asserted mid-operation; no out_valid is produced for the aborted sample.

Structure
REQ-032 SHALL place ATAN table, ITER_COUNT=7, data width 8 and internal width 10 in shared package nco_pkg, shared with the NCO.
REQ-033 SHALL implement the single CORDIC micro-rotation (x, y, z, i → x', y', z') as sub-module cordic_vec_stage, instantiated once and reused each cycle; FSM, freq and lock logic stay in the top.

Verification
REQ-034 SHALL cover: cos_in=127, sin_in=0 -> phase_out 0±2, out_valid exactly 9 cycles after acceptance, first freq_out=0.
REQ-035 SHALL cover: (cos,sin) = (0,127), (-128,0), (0,-128), applied in sequence -> phase_out 64±2, 128±2, 192±2; freq_out 64±2 from the second result on.
REQ-036 SHALL cover: 8-bit NCO output, phase_inc=8'h10, fed at each in_ready -> freq_out 16±2 from the second result, locked high from the 6th result (LOCK_COUNT=4).
REQ-037 SHALL cover: after lock, phase_inc switched to 8'h30 -> locked drops on the first jumped result and re-asserts 4 consistent results later, freq_out 48±2.
REQ-038 SHALL cover: reset pulsed during ITER cycle 3 -> no out_valid for that sample, all outputs 0, and in_ready=1 the cycle after reset deasserts.
REQ-039 SHALL cover: in_valid held high continuously -> in_ready low for 8 of every 9 cycles and exactly one acceptance per 9 cycles.
